result_stream_reader: RTL and testbench

RESULT_STREAM_READER -- requirements
Module: result_stream_reader

---
 rtl/result_stream_reader_if.sv | 30 +++
 rtl/result_stream_reader.sv | 143 ++++++++++++++
 tb/tb_result_stream_reader.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_stream_reader_if.sv
// Bundles the result-memory read port and the record output stream of result_stream_reader.
// master = the reader; slave = the memory/consumer side.
interface result_stream_reader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_kind;
    logic              out_last;

    modport master (
        output mem_en, mem_addr,
        input  mem_rdata,
        output out_valid, out_data, out_kind, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_en, mem_addr,
        output mem_rdata,
        input  out_valid, out_data, out_kind, out_last,
        output out_ready
    );
endinterface

// File: rtl/result_stream_reader.sv
// Scans a solver result memory word by word and streams each word out as a classified record
// (value / infinity / terminator), or a single negative-cycle record when the solver flagged one.
module result_stream_reader #(
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 14,
    parameter int                DEPTH        = 16383,
    parameter logic [DATA_W-1:0] INF_VALUE    = {DATA_W{1'b1}},
    parameter logic [DATA_W-1:0] TERM_VALUE   = '0,
    parameter bit                STOP_ON_TERM = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  n_exist,
    result_stream_reader_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       count
);

    typedef enum logic [2:0] {IDLE, NEG, READ, WAIT, EMIT, FIN} state_t;

    localparam logic [1:0] KIND_VALUE = 2'b00;
    localparam logic [1:0] KIND_INF   = 2'b01;
    localparam logic [1:0] KIND_TERM  = 2'b10;
    localparam logic [1:0] KIND_NEG   = 2'b11;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_nx;
    logic              start_q;
    logic              start_rise;
    logic              accept;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        kind_q;
    logic              last_q;
    logic [1:0]        rd_kind;
    logic              rd_last;
    logic              mem_en_c;
    logic              valid_c;

    assign start_rise = start & ~start_q;
    assign accept     = valid_c & bus.out_ready;

    // Terminator wins over infinity in case both markers are configured to the same value.
    always_comb begin
        if (bus.mem_rdata == TERM_VALUE)
            rd_kind = KIND_TERM;
        else if (bus.mem_rdata == INF_VALUE)
            rd_kind = KIND_INF;
        else
            rd_kind = KIND_VALUE;
        rd_last = (STOP_ON_TERM && (rd_kind == KIND_TERM)) || (addr == LAST_ADDR);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        mem_en_c = 1'b0;
        valid_c  = 1'b0;
        busy     = (state != IDLE);
        done     = 1'b0;
        case (state)
            IDLE: if (start_rise) state_nx = n_exist ? NEG : READ;
            NEG: begin
                valid_c = 1'b1;
                if (accept) state_nx = FIN;
            end
            READ: begin
                mem_en_c = 1'b1;
                state_nx = WAIT;
            end
            WAIT: state_nx = EMIT;
            EMIT: begin
                valid_c = 1'b1;
                if (accept) state_nx = last_q ? FIN : READ;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_nx;
            start_q <= start;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr   <= '0;
            data_q <= '0;
            kind_q <= KIND_VALUE;
            last_q <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        addr  <= '0;
                        count <= '0;
                        if (n_exist) begin
                            data_q <= '0;
                            kind_q <= KIND_NEG;
                            last_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    data_q <= bus.mem_rdata;
                    kind_q <= rd_kind;
                    last_q <= rd_last;
                end
                NEG: if (accept) count <= count + 1'b1;
                EMIT: begin
                    if (accept) begin
                        count <= count + 1'b1;
                        // last_q is forced at LAST_ADDR, so the address can never run past the end.
                        if (!last_q) addr <= addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_en    = mem_en_c;
    assign bus.mem_addr  = addr;
    assign bus.out_valid = valid_c;
    assign bus.out_data  = data_q;
    assign bus.out_kind  = kind_q;
    assign bus.out_last  = last_q;

endmodule

// File: tb/tb_result_stream_reader.sv
// Directed bench for result_stream_reader: default-parameter instance plus a DEPTH=4,
// scan-everything instance, each with a small behavioural result memory.
module tb_result_stream_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, n_exist_a = 1'b0;
    logic        start_b = 1'b0, n_exist_b = 1'b0;
    logic        busy_a, done_a, busy_b, done_b;
    logic [14:0] count_a, count_b;

    result_stream_reader_if #(.DATA_W(16), .ADDR_W(14)) bus_a ();
    result_stream_reader_if #(.DATA_W(16), .ADDR_W(14)) bus_b ();

    result_stream_reader dut_a (
        .clock   (clock),
        .reset   (reset),
        .start   (start_a),
        .n_exist (n_exist_a),
        .bus     (bus_a.master),
        .busy    (busy_a),
        .done    (done_a),
        .count   (count_a)
    );

    result_stream_reader #(.DEPTH(4), .STOP_ON_TERM(1'b0)) dut_b (
        .clock   (clock),
        .reset   (reset),
        .start   (start_b),
        .n_exist (n_exist_b),
        .bus     (bus_b.master),
        .busy    (busy_b),
        .done    (done_b),
        .count   (count_b)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] word;
        logic [15:0] data;
        logic [1:0]  kind;
        logic        last;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  kind;
        logic        last;
    } rec_t;

    vec_t        tbl[8];
    int          tbl_n = 0;
    rec_t        got_a[$], got_b[$];
    logic [15:0] mem_a[0:15];
    logic [15:0] mem_b[0:3];

    int n_checks = 0, n_fail = 0;
    int done_cnt_a = 0, rd_cnt_a = 0, max_addr_a = -1, stall_cmp = 0;
    int done_cnt_b = 0, rd_cnt_b = 0;
    logic        stalled_a = 1'b0;
    logic [18:0] hold_a = '0;

    always @(posedge clock) if (bus_a.mem_en) bus_a.mem_rdata <= mem_a[bus_a.mem_addr[3:0]];
    always @(posedge clock) if (bus_b.mem_en) bus_b.mem_rdata <= mem_b[bus_b.mem_addr[1:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (bus_a.out_valid && bus_a.out_ready)
            got_a.push_back('{data: bus_a.out_data, kind: bus_a.out_kind, last: bus_a.out_last});
        if (done_a) done_cnt_a++;
        if (bus_a.mem_en) begin
            rd_cnt_a++;
            if (int'(bus_a.mem_addr) > max_addr_a) max_addr_a = int'(bus_a.mem_addr);
        end
        if (stalled_a && bus_a.out_valid) begin
            stall_cmp++;
            check("stall_hold", {bus_a.out_data, bus_a.out_kind, bus_a.out_last}, hold_a);
        end
        stalled_a = bus_a.out_valid && !bus_a.out_ready;
        hold_a    = {bus_a.out_data, bus_a.out_kind, bus_a.out_last};
    end

    always @(negedge clock) begin
        if (bus_b.out_valid && bus_b.out_ready)
            got_b.push_back('{data: bus_b.out_data, kind: bus_b.out_kind, last: bus_b.out_last});
        if (done_b) done_cnt_b++;
        if (bus_b.mem_en) rd_cnt_b++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_a();
        got_a.delete();
        done_cnt_a = 0;
        rd_cnt_a   = 0;
        max_addr_a = -1;
        stall_cmp  = 0;
    endtask

    task automatic load_mem_a();
        for (int i = 0; i < 16; i++) mem_a[i] = 16'h1111;
        for (int i = 0; i < tbl_n; i++) mem_a[i] = tbl[i].word;
    endtask

    task automatic load_scan1();
        tbl[0] = '{16'h0005, 16'h0005, 2'b00, 1'b0};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 2'b01, 1'b0};
        tbl[2] = '{16'd12,   16'h000C, 2'b00, 1'b0};
        tbl[3] = '{16'h0000, 16'h0000, 2'b10, 1'b1};
        tbl_n  = 4;
        load_mem_a();
        mem_a[4] = 16'h0007;
    endtask

    task automatic start_edge_a(input logic nx);
        n_exist_a = nx;
        start_a   = 1'b1;
        tick();
        start_a   = 1'b0;
    endtask

    task automatic wait_done_a(input int target);
        for (int i = 0; i < 300 && done_cnt_a < target; i++) tick();
        check("done_pulses_a", done_cnt_a, target);
    endtask

    task automatic wait_got_a(input int n);
        for (int i = 0; i < 100 && got_a.size() < n; i++) tick();
        check("records_reached_a", got_a.size(), n);
    endtask

    task automatic wait_valid_a();
        for (int i = 0; i < 20 && !bus_a.out_valid; i++) tick();
        check("valid_reached_a", bus_a.out_valid, 1'b1);
    endtask

    task automatic compare_recs(input string tag, input rec_t got[$]);
        check($sformatf("%s_len", tag), got.size(), tbl_n);
        for (int i = 0; i < tbl_n; i++)
            if (i < got.size())
                check($sformatf("%s_rec%0d", tag, i),
                      {got[i].data, got[i].kind, got[i].last},
                      {tbl[i].data, tbl[i].kind, tbl[i].last});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem_a[i] = 16'h1111;
        mem_b[0] = 16'd0; mem_b[1] = 16'd3; mem_b[2] = 16'd0; mem_b[3] = 16'd9;

        repeat (2) @(posedge clock);
        #1;
        check("reset_a", {bus_a.mem_en, bus_a.out_valid, bus_a.out_last, busy_a, done_a,
                          bus_a.mem_addr, bus_a.out_data, bus_a.out_kind, count_a}, 64'd0);
        check("reset_b", {bus_b.mem_en, bus_b.out_valid, busy_b, done_b, count_b}, 64'd0);
        reset = 1'b0;
        tick();

        // Basic scan stops at the terminator, word 4 is never read.
        load_scan1();
        clear_a();
        start_edge_a(1'b0);
        check("busy_during_scan", busy_a, 1'b1);
        wait_done_a(1);
        compare_recs("scan1", got_a);
        check("scan1_count", count_a, 4);
        check("scan1_reads", rd_cnt_a, 4);
        check("scan1_max_addr", max_addr_a, 3);
        check("scan1_busy_after", busy_a, 1'b0);
        check("scan1_done_one_cycle", done_a, 1'b0);

        // Classification corners: near-infinity and small values are plain values.
        tbl[0] = '{16'h1234, 16'h1234, 2'b00, 1'b0};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 2'b01, 1'b0};
        tbl[2] = '{16'hFFFE, 16'hFFFE, 2'b00, 1'b0};
        tbl[3] = '{16'h0001, 16'h0001, 2'b00, 1'b0};
        tbl[4] = '{16'h0000, 16'h0000, 2'b10, 1'b1};
        tbl_n  = 5;
        load_mem_a();
        clear_a();
        start_edge_a(1'b0);
        wait_done_a(1);
        compare_recs("classify", got_a);
        check("classify_count", count_a, 5);
        check("classify_max_addr", max_addr_a, 4);

        // Negative cycle: one record, no memory traffic.
        tbl[0] = '{16'h0000, 16'h0000, 2'b11, 1'b1};
        tbl_n  = 1;
        clear_a();
        start_edge_a(1'b1);
        n_exist_a = 1'b0;
        wait_done_a(1);
        compare_recs("neg", got_a);
        check("neg_reads", rd_cnt_a, 0);
        check("neg_count", count_a, 1);

        // Consumer stall on the 2nd record; n_exist rises mid-scan and must be ignored.
        load_scan1();
        clear_a();
        start_edge_a(1'b0);
        n_exist_a = 1'b1;
        wait_got_a(1);
        bus_a.out_ready = 1'b0;
        wait_valid_a();
        repeat (5) tick();
        bus_a.out_ready = 1'b1;
        wait_done_a(1);
        n_exist_a = 1'b0;
        compare_recs("stall", got_a);
        check("stall_reads", rd_cnt_a, 4);
        check("stall_compares_seen", stall_cmp >= 4, 1'b1);

        // Scan-all instance: terminators do not end the scan, DEPTH-1 does.
        tbl[0] = '{16'd0, 16'd0, 2'b10, 1'b0};
        tbl[1] = '{16'd3, 16'd3, 2'b00, 1'b0};
        tbl[2] = '{16'd0, 16'd0, 2'b10, 1'b0};
        tbl[3] = '{16'd9, 16'd9, 2'b00, 1'b1};
        tbl_n  = 4;
        got_b.delete();
        done_cnt_b = 0;
        rd_cnt_b   = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 300 && done_cnt_b < 1; i++) tick();
        check("done_pulses_b", done_cnt_b, 1);
        compare_recs("scanall", got_b);
        check("scanall_count", count_b, 4);
        check("scanall_reads", rd_cnt_b, 4);

        // Reset while the 3rd record is being presented.
        load_scan1();
        clear_a();
        start_edge_a(1'b0);
        wait_got_a(2);
        bus_a.out_ready = 1'b0;
        wait_valid_a();
        check("abort_pre_data", {bus_a.out_data, bus_a.out_kind}, {16'h000C, 2'b00});
        reset = 1'b1;
        #1;
        check("abort_zeroed", {bus_a.mem_en, bus_a.out_valid, bus_a.out_last, busy_a, done_a,
                               bus_a.mem_addr, bus_a.out_data, bus_a.out_kind, count_a}, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        bus_a.out_ready = 1'b1;
        repeat (5) tick();
        check("abort_no_done", done_cnt_a, 0);
        check("abort_no_autostart", busy_a, 1'b0);
        clear_a();
        start_edge_a(1'b0);
        wait_done_a(1);
        compare_recs("after_abort", got_a);

        // start held high across FIN plus a start edge while busy: exactly two scans.
        clear_a();
        start_a = 1'b1;
        tick();
        repeat (3) tick();
        start_a = 1'b0;
        tick();
        start_a = 1'b1;
        wait_done_a(1);
        repeat (10) tick();
        check("held_start_idle", busy_a, 1'b0);
        check("held_start_done_cnt", done_cnt_a, 1);
        check("held_start_records", got_a.size(), 4);
        start_a = 1'b0;
        tick();
        start_a = 1'b1;
        tick();
        wait_done_a(2);
        start_a = 1'b0;
        check("two_scans_records", got_a.size(), 8);
        check("two_scans_count", count_a, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
